queue_arb_cntrl: RTL and testbench

QUEUE_ARB_CNTRL -- requirements
Module: queue_arb_cntrl

---
 rtl/queue_arb_cntrl_pkg.sv | 18 +
 rtl/queue_arb_cntrl_rr.sv | 28 ++
 rtl/queue_arb_cntrl.sv | 126 ++++++++++++
 tb/tb_queue_arb_cntrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/queue_arb_cntrl_pkg.sv
// Shared definitions for the queue arbitration controller: FSM states and
// parameter legality helpers.
package queue_arb_cntrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } q_state_e;

  function automatic bit nreq_legal(input int unsigned n);
    return (n >= 2) && (n <= 8);
  endfunction

  function automatic bit n_legal(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/queue_arb_cntrl_rr.sv
// Round-robin one-hot arbiter: searches upward from i_ptr with wrap and
// grants the first active request when enabled.
module rr_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [NREQ-1:0]  o_gnt
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (32'(i_ptr) + k) % NREQ;
      if (i_en && !w_found && i_req[idx[IDX_W-1:0]]) begin
        o_gnt[idx[IDX_W-1:0]] = 1'b1;
        w_found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_arb_cntrl.sv
// Shared-queue controller: round-robin enqueue arbitration, wrap-bit pointers,
// registered status and a flush/drain FSM. Storage lives outside this block.
module queue_arb_cntrl
  import queue_arb_cntrl_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = $clog2(N),
  parameter int unsigned IDX_W  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_req_vld,
  output logic [NREQ-1:0]   o_req_gnt,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_wa,
  output logic [IDX_W-1:0]  o_widx,
  output logic              o_deq_vld,
  input  logic              i_deq_rdy,
  output logic              o_ren,
  output logic [ADDR_W-1:0] o_ra,
  input  logic              i_flush,
  output logic              o_flush_done,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level
);

  if (!nreq_legal(NREQ)) begin : g_bad_nreq
    $error("queue_arb_cntrl: NREQ must be in 2..8");
  end
  if (!n_legal(N)) begin : g_bad_n
    $error("queue_arb_cntrl: N must be a power of 2 and >= 2");
  end

  q_state_e         r_state, w_state_nxt;
  logic [ADDR_W:0]  r_wa, r_ra, w_wa_nxt, w_ra_nxt;
  logic [ADDR_W:0]  r_level;
  logic             r_full, r_empty;
  logic             r_flush_done, w_flush_done_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt, w_widx;
  logic [NREQ-1:0]  w_gnt;
  logic             w_en, w_push, w_pop;

  assign w_en  = !rst && (r_state == RUN) && !r_full;
  assign w_pop = !rst && !r_empty && i_deq_rdy;

  rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .i_req (i_req_vld),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt)
  );

  assign w_push = |w_gnt;

  always_comb begin
    w_widx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_widx = IDX_W'(i);
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_push) w_ptr_nxt = (32'(w_widx) == NREQ - 1) ? '0 : w_widx + 1'b1;
  end

  assign w_wa_nxt = r_wa + (ADDR_W+1)'(w_push);
  assign w_ra_nxt = r_ra + (ADDR_W+1)'(w_pop);

  // The done pulse is issued while still in DRAIN; RUN follows it, so grants
  // resume the cycle after the pulse.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_done_nxt = 1'b0;
    case (r_state)
      RUN: begin
        if (i_flush) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_flush_done)  w_state_nxt      = RUN;
        else if (r_empty)  w_flush_done_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_wa         <= '0;
      r_ra         <= '0;
      r_ptr        <= '0;
      r_level      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wa         <= w_wa_nxt;
      r_ra         <= w_ra_nxt;
      r_ptr        <= w_ptr_nxt;
      r_level      <= w_wa_nxt - w_ra_nxt;
      r_full       <= (w_wa_nxt[ADDR_W] != w_ra_nxt[ADDR_W]) &&
                      (w_wa_nxt[ADDR_W-1:0] == w_ra_nxt[ADDR_W-1:0]);
      r_empty      <= (w_wa_nxt == w_ra_nxt);
      r_flush_done <= w_flush_done_nxt;
    end
  end

  assign o_req_gnt    = w_gnt;
  assign o_wen        = w_push;
  assign o_wa         = r_wa[ADDR_W-1:0];
  assign o_widx       = w_widx;
  assign o_deq_vld    = !r_empty;
  assign o_ren        = w_pop;
  assign o_ra         = r_ra[ADDR_W-1:0];
  assign o_flush_done = r_flush_done;
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_level      = r_level;

endmodule

// File: tb/tb_queue_arb_cntrl.sv
// Directed self-checking bench for queue_arb_cntrl (NREQ=4, N=16).
module tb_queue_arb_cntrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vld;
  logic [3:0] req_gnt;
  logic       wen;
  logic [3:0] wa;
  logic [1:0] widx;
  logic       deq_vld;
  logic       deq_rdy;
  logic       ren;
  logic [3:0] ra;
  logic       flush;
  logic       flush_done;
  logic       full;
  logic       empty;
  logic [4:0] level;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  queue_arb_cntrl #(
    .NREQ (4),
    .N    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_vld    (req_vld),
    .o_req_gnt    (req_gnt),
    .o_wen        (wen),
    .o_wa         (wa),
    .o_widx       (widx),
    .o_deq_vld    (deq_vld),
    .i_deq_rdy    (deq_rdy),
    .o_ren        (ren),
    .o_ra         (ra),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .o_full       (full),
    .o_empty      (empty),
    .o_level      (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1-2 ns after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_vld = 4'b1111; deq_rdy = 1'b1; flush = 1'b0;
    tick; tick;
    #1;
    check("rst_gnt", req_gnt, 0);
    check("rst_wen", wen, 0);
    check("rst_ren", ren, 0);

    rst = 1'b0; req_vld = 4'b0000; deq_rdy = 1'b1;
    #1;
    check("por_empty", empty, 1);
    check("por_full", full, 0);
    check("por_level", level, 0);
    check("por_deq_vld", deq_vld, 0);
    check("por_flush_done", flush_done, 0);
    check("empty_no_pop", ren, 0);
    tick;

    // fill: rotation 0,1,2,3,... for 16 cycles
    req_vld = 4'b1111; deq_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("fill_gnt", req_gnt, 32'(1) << (i % 4));
      check("fill_widx", widx, i % 4);
      check("fill_wa", wa, i);
      check("fill_level", level, i);
      tick;
    end
    #1;
    check("full_flag", full, 1);
    check("full_level", level, 16);
    check("full_no_gnt", req_gnt, 0);
    check("full_no_wen", wen, 0);
    tick;

    // full + pop: no bypass grant, next grant goes to requester 0
    deq_rdy = 1'b1;
    #1;
    check("fpop_ren", ren, 1);
    check("fpop_ra", ra, 0);
    check("fpop_no_gnt", req_gnt, 0);
    tick;
    deq_rdy = 1'b0;
    #1;
    check("fpop_level", level, 15);
    check("fpop_full", full, 0);
    check("fpop_next_gnt", req_gnt, 4'b0001);
    check("fpop_wa", wa, 0);
    tick;

    // drain 11 entries to reach level 5 (wa=1, ra=12)
    req_vld = 4'b0000; deq_rdy = 1'b1;
    repeat (11) tick;
    #1;
    check("lvl5", level, 5);

    // steady push+pop through the wrap
    req_vld = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("ss_level", level, 5);
      check("ss_gnt", req_gnt, 4'b0100);
      check("ss_ren", ren, 1);
      check("ss_wa", wa, (1 + k) % 16);
      check("ss_ra", ra, (12 + k) % 16);
      tick;
    end
    #1;
    check("ss_wa_end", wa, 5);
    check("ss_ra_end", ra, 0);

    // two pops to level 3, then flush
    req_vld = 4'b0000;
    tick; tick;
    req_vld = 4'b1111; flush = 1'b1;
    #1;
    check("fl_level", level, 3);
    check("fl_cycle_gnt", req_gnt, 4'b1000);
    check("fl_cycle_ren", ren, 1);
    tick;
    flush = 1'b0;
    for (int d = 0; d < 3; d++) begin
      #1;
      check("dr_level", level, 3 - d);
      check("dr_no_gnt", req_gnt, 0);
      check("dr_ren", ren, 1);
      check("dr_done_low", flush_done, 0);
      tick;
    end
    #1;
    check("dr_empty", empty, 1);
    check("dr_empty_gnt", req_gnt, 0);
    check("dr_empty_done", flush_done, 0);
    tick;
    #1;
    check("dr_done_pulse", flush_done, 1);
    check("dr_done_gnt", req_gnt, 0);
    tick;
    deq_rdy = 1'b0;
    #1;
    check("dr_done_end", flush_done, 0);
    check("resume_gnt", req_gnt, 4'b0001);
    tick;
    #1;
    check("resume2_gnt", req_gnt, 4'b0010);
    tick;

    // flush at level 2, then reset mid-drain
    req_vld = 4'b0000; flush = 1'b1;
    #1;
    check("rd_level", level, 2);
    tick;
    flush = 1'b0; req_vld = 4'b1111;
    #1;
    check("rd_drain_gnt", req_gnt, 0);
    tick;
    rst = 1'b1;
    #1;
    check("rd_rst_gnt", req_gnt, 0);
    tick;
    rst = 1'b0;
    #1;
    check("rd_level0", level, 0);
    check("rd_empty", empty, 1);
    check("rd_done", flush_done, 0);
    check("rd_first_gnt", req_gnt, 4'b0001);
    tick;
    req_vld = 4'b0000; deq_rdy = 1'b1;
    #1;
    check("rd_done2", flush_done, 0);
    check("rd_pop", ren, 1);
    tick;

    // flush while already empty: RUN -> DRAIN -> RUN
    flush = 1'b1;
    #1;
    check("ef_empty", empty, 1);
    tick;
    flush = 1'b0; req_vld = 4'b1111;
    #1;
    check("ef_drain_gnt", req_gnt, 0);
    check("ef_done_low", flush_done, 0);
    tick;
    #1;
    check("ef_done_pulse", flush_done, 1);
    check("ef_done_gnt", req_gnt, 0);
    tick;
    #1;
    check("ef_done_end", flush_done, 0);
    check("ef_resume_gnt", req_gnt, 4'b0010);
    tick;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
